mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : two-requester (instruction / data) arbiter onto one shared memory port.
// Latency : request seen in IDLE at cycle N drives mem_read/mem_write from N+1; x_resp is combinational with mem_resp.
// Backpress: requesters hold their request until x_resp; one transaction in flight, one idle cycle between grants.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   i_read, i_address    instruction-side read request (read-only side)
//   i_rdata, i_resp      instruction-side response (rdata is 0 unless i_resp)
//   d_read, d_write,     data-side request; write wins if both are high
//   d_byte_enable,
//   d_address, d_wdata
//   d_rdata, d_resp      data-side response (rdata is 0 unless d_resp)
//   mem_*                shared memory command (registered) / response
//   grant_d              high while the data side owns the memory port
//
// Configuration macro: MEM_ARBITER_RR_EN
//   defined   : ties in IDLE alternate (round-robin on the last grant), first tie after reset goes to D
//   undefined : fixed priority, D always wins ties
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   req_i;
  logic   req_d;
  logic   pick_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

`ifdef MEM_ARBITER_RR_EN
  // Set when the most recent grant went to the data side.
  logic last_d;

  // On a tie, hand the port to whichever side did not get it last time.
  always_comb begin
    pick_d = req_d && (!req_i || !last_d);
  end
`else
  always_comb begin
    pick_d = req_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= 4'b0000;
      mem_address     <= 32'h0;
      mem_wdata       <= 32'h0;
      grant_d         <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_d          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state           <= SERVE_D;
            grant_d         <= 1'b1;
            mem_address     <= d_address;
            mem_wdata       <= d_wdata;
            // A simultaneous read is dropped in favour of the write.
            mem_write       <= d_write;
            mem_read        <= ~d_write;
            mem_byte_enable <= d_write ? d_byte_enable : 4'b1111;
`ifdef MEM_ARBITER_RR_EN
            last_d          <= 1'b1;
`endif
          end else if (req_i) begin
            state           <= SERVE_I;
            grant_d         <= 1'b0;
            mem_address     <= i_address;
            mem_wdata       <= 32'h0;
            mem_write       <= 1'b0;
            mem_read        <= 1'b1;
            mem_byte_enable <= 4'b0000;
`ifdef MEM_ARBITER_RR_EN
            last_d          <= 1'b0;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          // Command fields stay frozen until memory answers; requests seen
          // meanwhile are only considered once we are back in IDLE.
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            grant_d   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          grant_d   <= 1'b0;
        end
      endcase
    end
  end

  // Responses are steered combinationally; a mem_resp seen in IDLE goes nowhere.
  assign i_resp  = (state == SERVE_I) && mem_resp;
  assign d_resp  = (state == SERVE_D) && mem_resp;
  assign i_rdata = i_resp ? mem_rdata : 32'h0;
  assign d_rdata = d_resp ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter (directed scenarios + randomized model check).
// Latency : inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpress: bench holds requests until the response cycle, memory delay is randomized.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        grant_d;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_last_d;  // reference model: last grant went to D

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .grant_d(grant_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
    m_last_d = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; d_write = 1; d_address = 32'h44; d_wdata = 32'h1234; d_byte_enable = 4'hf;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, grant_d, i_resp, d_resp} !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%b wr=%b be=%h addr=%h wdata=%h grant_d=%b i_resp=%b d_resp=%b, required all 0",
               mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, grant_d, i_resp, d_resp);
    end
    tick();
    rst = 1;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_first_cycle: mem_write=%b required 0", mem_write);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_write, mem_read, grant_d, mem_address} !== {1'b1, 1'b0, 1'b1, 32'h44}) begin
      n_fail++;
      $display("FAIL reset_release_write: wr=%b rd=%b grant_d=%b addr=%h required 1 0 1 00000044",
               mem_write, mem_read, grant_d, mem_address);
    end
    tick();
    mem_resp = 1; mem_rdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if ({d_resp, i_resp} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release_resp: d_resp=%b i_resp=%b required 1 0", d_resp, i_resp);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_i_read();
    do_reset();
    i_read = 1; i_address = 32'h0000_0060;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b0) begin
      n_fail++; $display("FAIL i_read_cycle_n: mem_read=%b required 0", mem_read);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin
        mem_resp = 1; mem_rdata = 32'h0051_3023;
      end
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, mem_byte_enable, mem_address, grant_d} !== {1'b1, 1'b0, 4'h0, 32'h60, 1'b0}) begin
        n_fail++;
        $display("FAIL i_read_cmd k=%0d: rd=%b wr=%b be=%h addr=%h grant_d=%b required 1 0 0 00000060 0",
                 k, mem_read, mem_write, mem_byte_enable, mem_address, grant_d);
      end
      n_checks++;
      if ({i_resp, d_resp, i_rdata} !== {(k == 3), 1'b0, (k == 3) ? 32'h0051_3023 : 32'h0}) begin
        n_fail++;
        $display("FAIL i_read_resp k=%0d: i_resp=%b d_resp=%b i_rdata=%h", k, i_resp, d_resp, i_rdata);
      end
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({mem_read, i_resp} !== 2'b00) begin
      n_fail++; $display("FAIL i_read_after: mem_read=%b i_resp=%b required 0 0", mem_read, i_resp);
    end
  endtask

  task automatic test_d_write();
    int resp_count = 0;
    do_reset();
    d_write = 1; d_address = 32'h0000_1004; d_wdata = 32'hDEAD_BEEF; d_byte_enable = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) mem_resp = 1;
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, grant_d} !==
          {1'b0, 1'b1, 4'b0011, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1}) begin
        n_fail++;
        $display("FAIL d_write_cmd k=%0d: rd=%b wr=%b be=%h addr=%h wdata=%h grant_d=%b",
                 k, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, grant_d);
      end
      if (d_resp) resp_count++;
    end
    tick();
    idle_inputs();
    @(negedge clk);
    if (d_resp) resp_count++;
    n_checks++;
    if (resp_count != 1) begin
      n_fail++; $display("FAIL d_write_resp_count: saw %0d d_resp pulses, required 1", resp_count);
    end
  endtask

  task automatic test_tie();
    bit exp_d;
    do_reset();
    i_read = 1; i_address = 32'h100;
    d_write = 1; d_address = 32'h900; d_wdata = 32'h5; d_byte_enable = 4'hf;
    for (int t = 0; t < 4; t++) begin
      exp_d = RR ? (t % 2 == 0) : 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if ({grant_d, mem_write, mem_read} !== {exp_d, exp_d, !exp_d}) begin
        n_fail++;
        $display("FAIL tie_grant t=%0d: grant_d=%b wr=%b rd=%b required grant_d=%b", t, grant_d, mem_write, mem_read, exp_d);
      end
      tick();
      mem_resp = 1; mem_rdata = 32'hA000_0000 + t;
      @(negedge clk);
      n_checks++;
      if ({d_resp, i_resp} !== {exp_d, !exp_d}) begin
        n_fail++; $display("FAIL tie_resp t=%0d: d_resp=%b i_resp=%b required d_resp=%b", t, d_resp, i_resp, exp_d);
      end
      tick();
      mem_resp = 0;
      if (t == 3) idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write} !== 2'b00) begin
        n_fail++; $display("FAIL tie_idle_gap t=%0d: rd=%b wr=%b required 0 0", t, mem_read, mem_write);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_read = 1; i_address = 32'h80;
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_grant: mem_read=%b required 1", mem_read);
    end
    tick();
    rst = 0;
    tick();
    rst = 1; i_read = 0; mem_resp = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    n_checks++;
    if ({i_resp, d_resp, mem_read, i_rdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_mid_stray: i_resp=%b d_resp=%b mem_read=%b i_rdata=%h required all 0", i_resp, d_resp, mem_read, i_rdata);
    end
    tick();
    mem_resp = 0;
  endtask

  task automatic test_rw_both();
    do_reset();
    d_read = 1; d_write = 1; d_address = 32'h200; d_wdata = 32'h7777_0001; d_byte_enable = 4'b0101;
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_write, mem_read, mem_address, mem_byte_enable} !== {1'b1, 1'b0, 32'h200, 4'b0101}) begin
      n_fail++;
      $display("FAIL rw_both_cmd: wr=%b rd=%b addr=%h be=%h required 1 0 00000200 5", mem_write, mem_read, mem_address, mem_byte_enable);
    end
    tick();
    d_address = 32'h300;
    @(negedge clk);
    n_checks++;
    if (mem_address !== 32'h200) begin
      n_fail++; $display("FAIL rw_both_stable: mem_address=%h required 00000200", mem_address);
    end
    tick();
    mem_resp = 1;
    @(negedge clk);
    n_checks++;
    if (d_resp !== 1'b1) begin
      n_fail++; $display("FAIL rw_both_resp: d_resp=%b required 1", d_resp);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit ri, rdr, rdw, want_d, exp_rd, exp_wr, stray;
    logic [3:0]  exp_be, be;
    logic [31:0] exp_addr, exp_wdata, rdata;
    int pick, dly;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      pick = $urandom_range(1, 7);
      ri = pick[0]; rdr = pick[1]; rdw = pick[2];
      be = 4'($urandom);
      i_read = ri; d_read = rdr; d_write = rdw;
      i_address = $urandom; d_address = $urandom; d_wdata = $urandom; d_byte_enable = be;
      mem_resp = 0;
      // Model: who wins, and what the shared port must carry.
      want_d = (rdr | rdw) && (!ri || (RR ? !m_last_d : 1'b1));
      m_last_d = want_d;
      exp_rd = want_d ? !rdw : 1'b1;
      exp_wr = want_d & rdw;
      exp_be = !want_d ? 4'h0 : (rdw ? be : 4'hf);
      exp_addr = want_d ? d_address : i_address;
      exp_wdata = d_wdata;
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
        n_fail++; $display("FAIL rand_idle it=%0d: rd=%b wr=%b i_resp=%b d_resp=%b required 0", it, mem_read, mem_write, i_resp, d_resp);
      end
      dly = $urandom_range(0, 3);
      for (int k = 0; k <= dly; k++) begin
        tick();
        i_address = $urandom; d_address = $urandom; d_wdata = $urandom;
        rdata = $urandom;
        mem_rdata = rdata;
        mem_resp = (k == dly);
        @(negedge clk);
        n_checks++;
        if ({mem_read, mem_write, mem_byte_enable, mem_address, grant_d} !== {exp_rd, exp_wr, exp_be, exp_addr, want_d} ||
            (exp_wr && mem_wdata !== exp_wdata)) begin
          n_fail++;
          $display("FAIL rand_cmd it=%0d k=%0d: rd=%b wr=%b be=%h addr=%h wdata=%h gd=%b required %b %b %h %h %h %b",
                   it, k, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, grant_d,
                   exp_rd, exp_wr, exp_be, exp_addr, exp_wdata, want_d);
        end
        n_checks++;
        if ({i_resp, d_resp, i_rdata, d_rdata} !==
            {(k == dly) && !want_d, (k == dly) && want_d,
             ((k == dly) && !want_d) ? rdata : 32'h0, ((k == dly) && want_d) ? rdata : 32'h0}) begin
          n_fail++;
          $display("FAIL rand_resp it=%0d k=%0d: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h mem_rdata=%h want_d=%b",
                   it, k, i_resp, d_resp, i_rdata, d_rdata, rdata, want_d);
        end
      end
      tick();
      stray = 1'($urandom);
      idle_inputs();
      mem_resp = stray;
      @(negedge clk);
      n_checks++;
      if ({mem_read, mem_write, grant_d, i_resp, d_resp} !== 5'b0) begin
        n_fail++;
        $display("FAIL rand_after it=%0d: rd=%b wr=%b gd=%b i_resp=%b d_resp=%b stray=%b required 0",
                 it, mem_read, mem_write, grant_d, i_resp, d_resp, stray);
      end
      tick();
    end
  endtask

  initial begin
    rst = 0;
    i_address = 0; d_address = 0; d_wdata = 0; d_byte_enable = 0; mem_rdata = 0;
    idle_inputs();
    test_reset();
    test_single_i_read();
    test_d_write();
    test_tie();
    test_reset_mid();
    test_rw_both();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
